// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: bit-slip aligner and TMDS symbol decoder for one HDMI/DVI channel.
//   pixclk   - pixel clock, all logic on the rising edge
//   rst_n    - synchronous active-low reset
//   raw_bits - unaligned deserialized word, bit 0 received first
//   VD/CD    - decoded video data / control data {C1,C0}
//   VDE      - 1 for a data symbol, 0 for a control token or while unlocked
//   locked   - alignment lock status
//   offset   - current bit-slip offset, 0..9
module tmds_channel_decoder #(
  parameter int LOCK_TOKENS    = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       pixclk,
  input  logic       rst_n,
  input  logic [9:0] raw_bits,
  output logic [7:0] VD,
  output logic [1:0] CD,
  output logic       VDE,
  output logic       locked,
  output logic [3:0] offset
);
  localparam int RW = $clog2(LOCK_TOKENS + 1);
  localparam int TW = $clog2(SEARCH_TIMEOUT);
  localparam int GW = $clog2(LOSS_TIMEOUT);
  localparam logic [RW-1:0] RUN_LAST = RW'(LOCK_TOKENS - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(SEARCH_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(LOSS_TIMEOUT - 1);
  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t state, state_n;
  logic [9:0] prev_raw, sym, window;
  logic [RW-1:0] run, run_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [GW-1:0] gap, gap_n;
  logic [3:0] offset_n;
  logic [7:0] q, x, dec_vd;
  logic [1:0] tok_cd;
  logic is_tok;
  // offset 0 selects prev_raw whole, so every offset sees the same 3-edge latency
  assign window = 10'({raw_bits, prev_raw} >> offset);
  assign is_tok = sym == TOK0 || sym == TOK1 || sym == TOK2 || sym == TOK3;
  assign tok_cd = sym == TOK1 ? 2'b01 : sym == TOK2 ? 2'b10 : sym == TOK3 ? 2'b11 : 2'b00;
  assign q = sym[9] ? ~sym[7:0] : sym[7:0];
  // x[0] = q[0]; x[i] = q[i]^q[i-1]; XNOR-coded symbols invert the upper seven bits
  assign x = q ^ {q[6:0], 1'b0};
  assign dec_vd = sym[8] ? x : {~x[7:1], x[0]};
  assign locked = state == LOCKED;
  always_comb begin
    state_n = state;
    run_n = run;
    tmr_n = tmr;
    gap_n = gap;
    offset_n = offset;
    if (state == SEARCH) begin
      run_n = is_tok ? run + 1'b1 : '0;
      tmr_n = tmr + 1'b1;
      // a completed token run beats a simultaneous timeout
      if (is_tok && run == RUN_LAST) begin
        state_n = LOCKED;
        gap_n = '0;
      end else if (tmr == TMR_LAST) begin
        offset_n = offset == 4'd9 ? 4'd0 : offset + 4'd1;
        tmr_n = '0;
        run_n = '0;
      end
    end else begin
      gap_n = is_tok ? '0 : gap + 1'b1;
      if (!is_tok && gap == GAP_LAST) begin
        state_n = SEARCH;
        run_n = '0;
        tmr_n = '0;
        gap_n = '0;
      end
    end
  end
  always_ff @(posedge pixclk) begin
    if (!rst_n) begin
      state <= SEARCH;
      run <= '0;
      tmr <= '0;
      gap <= '0;
      offset <= '0;
      prev_raw <= '0;
      sym <= '0;
      VD <= '0;
      CD <= '0;
      VDE <= 1'b0;
    end else begin
      state <= state_n;
      run <= run_n;
      tmr <= tmr_n;
      gap <= gap_n;
      offset <= offset_n;
      prev_raw <= raw_bits;
      sym <= window;
      // blanking follows the next state so it changes on the same edge as locked
      VD <= state_n == LOCKED && !is_tok ? dec_vd : '0;
      CD <= state_n == LOCKED && is_tok ? tok_cd : '0;
      VDE <= state_n == LOCKED && !is_tok;
    end
  end
endmodule
